// File: rtl/Purple_Jade_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : Purple_Jade_pkg
//  Description : Shared FE constants, the fetch queue entry type and the
//                wrapping PC increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package Purple_Jade_pkg;

    localparam int I_ROM_DEPTH_P         = 32;
    localparam int WORD_SIZE_P           = 16;
    localparam int I_FETCH_QUEUE_DEPTH_P = 2;
    localparam int I_FETCH_ADDR_WIDTH_P  = $clog2(I_ROM_DEPTH_P);

    typedef struct packed {
        logic [I_FETCH_ADDR_WIDTH_P-1:0] pc;
        logic [WORD_SIZE_P-1:0]          inst;
    } fetch_entry_s;

    // The last ROM word is followed by word 0 even when the depth is not a
    // power of two.
    function automatic logic [I_FETCH_ADDR_WIDTH_P-1:0] next_pc(
        input logic [I_FETCH_ADDR_WIDTH_P-1:0] a
    );
        if (a == I_FETCH_ADDR_WIDTH_P'(I_ROM_DEPTH_P - 1))
            return '0;
        return a + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : i_fetch_if
//  Description : Fetch-to-decode valid/ready handshake carrying {pc, inst}.
//  Revision    : 1.0 - initial release
// ============================================================================
interface i_fetch_if;
    import Purple_Jade_pkg::*;

    logic                            inst_v_o;
    logic [WORD_SIZE_P-1:0]          inst_o;
    logic [I_FETCH_ADDR_WIDTH_P-1:0] pc_o;
    logic                            inst_ready_i;

    modport master (
        output inst_v_o,
        output inst_o,
        output pc_o,
        input  inst_ready_i
    );

    modport slave (
        input  inst_v_o,
        input  inst_o,
        input  pc_o,
        output inst_ready_i
    );

endinterface
`default_nettype wire

// File: rtl/i_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Counted FIFO of fetch entries; flush outranks enqueue and the
//                same-cycle enqueue lands in the freshly emptied queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import Purple_Jade_pkg::*;
#(
    parameter int DEPTH = I_FETCH_QUEUE_DEPTH_P
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_enq,
    input  wire fetch_entry_s i_entry,
    input  wire logic         i_deq,
    input  wire logic         i_flush,
    output fetch_entry_s      o_head,
    output logic              o_full,
    output logic              o_empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    fetch_entry_s         r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_rd;
    logic [c_PTR_W-1:0]   r_wr;
    logic [c_CNT_W-1:0]   r_cnt;

    logic                 w_do_enq;
    logic                 w_do_deq;
    logic [c_PTR_W-1:0]   w_wr_idx;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        if (p == c_PTR_W'(DEPTH - 1))
            return '0;
        return p + 1'b1;
    endfunction

    assign o_full   = (r_cnt == c_CNT_W'(DEPTH));
    assign o_empty  = (r_cnt == '0);
    assign o_head   = r_mem[r_rd];

    // A pop in the flush cycle is absorbed by the flush itself.
    assign w_do_deq = i_deq && !o_empty && !i_flush;
    assign w_do_enq = i_enq && (!o_full || w_do_deq || i_flush);
    assign w_wr_idx = i_flush ? '0 : r_wr;

    always_ff @(posedge clk) begin
        if (w_do_enq && !rst)
            r_mem[w_wr_idx] <= i_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_rd  <= '0;
            r_wr  <= w_do_enq ? ptr_inc('0) : '0;
            r_cnt <= w_do_enq ? c_CNT_W'(1) : '0;
        end else begin
            if (w_do_enq)
                r_wr <= ptr_inc(r_wr);
            if (w_do_deq)
                r_rd <= ptr_inc(r_rd);
            case ({w_do_enq, w_do_deq})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/i_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : i_fetch
//  Description : Instruction fetch front end: PC, redirect mux, ROM read and
//                fetch queue toward decode.
//                Optional macro I_FETCH_STOP_AT_END_EN stops fetch after the
//                last ROM word and raises end_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module i_fetch
    import Purple_Jade_pkg::*;
#(
    parameter  int RESET_PC_P    = 0,
    parameter  int QUEUE_DEPTH_P = I_FETCH_QUEUE_DEPTH_P,
    localparam int ADDR_WIDTH_LP = $clog2(I_ROM_DEPTH_P)
) (
    input  wire logic                     clk_i,
    input  wire logic                     reset_i,
    output logic [ADDR_WIDTH_LP-1:0]      rom_addr_o,
    input  wire logic [WORD_SIZE_P-1:0]   rom_data_i,
    input  wire logic                     redirect_v_i,
    input  wire logic [ADDR_WIDTH_LP-1:0] redirect_pc_i,
    i_fetch_if.master                     dec_if,
    output logic                          end_o
);

    localparam logic [ADDR_WIDTH_LP-1:0] c_LAST_PC = ADDR_WIDTH_LP'(I_ROM_DEPTH_P - 1);
    localparam logic [ADDR_WIDTH_LP:0]   c_ROM_LIM = (ADDR_WIDTH_LP + 1)'(I_ROM_DEPTH_P);

    logic [ADDR_WIDTH_LP-1:0] r_pc;
    logic                     w_xfer;
    logic                     w_enq;
    logic                     w_stop;
    logic                     w_full;
    logic                     w_empty;
    fetch_entry_s             w_new;
    fetch_entry_s             w_head;

    assign rom_addr_o = redirect_v_i ? redirect_pc_i : r_pc;
    assign w_xfer     = dec_if.inst_v_o && dec_if.inst_ready_i;
    assign w_enq      = (!w_full || w_xfer || redirect_v_i) && !w_stop;
    assign w_new      = '{pc: rom_addr_o, inst: rom_data_i};

    always_ff @(posedge clk_i) begin
        if (reset_i)
            r_pc <= ADDR_WIDTH_LP'(RESET_PC_P);
        else if (w_enq)
            r_pc <= next_pc(rom_addr_o);
    end

`ifdef I_FETCH_STOP_AT_END_EN
    logic r_end;

    // Setting wins over a redirect so a jump straight to the last word stops too.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            r_end <= 1'b0;
        else if (w_enq && (rom_addr_o == c_LAST_PC))
            r_end <= 1'b1;
        else if (redirect_v_i)
            r_end <= 1'b0;
    end

    assign w_stop = r_end && !redirect_v_i;
    assign end_o  = r_end;
`else
    logic w_unused_last;

    assign w_unused_last = ^c_LAST_PC;
    assign w_stop        = 1'b0;
    assign end_o         = 1'b0;
`endif

    fetch_queue #(
        .DEPTH   (QUEUE_DEPTH_P)
    ) u_queue (
        .clk     (clk_i),
        .rst     (reset_i),
        .i_enq   (w_enq),
        .i_entry (w_new),
        .i_deq   (w_xfer),
        .i_flush (redirect_v_i),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign dec_if.inst_v_o = !w_empty;
    assign dec_if.inst_o   = w_empty ? '0 : w_head.inst;
    assign dec_if.pc_o     = w_empty ? '0 : w_head.pc;

    a_redirect_in_range : assert property (
        @(posedge clk_i) disable iff (reset_i)
        redirect_v_i |-> ({1'b0, redirect_pc_i} < c_ROM_LIM)
    );

endmodule
`default_nettype wire
